// File: rtl/mesh_traffic_injector_pkg.sv
// Shared constants for the mesh traffic injector: flit field widths,
// injection mode encodings, LFSR polynomial and seed handling.
package mesh_traffic_injector_pkg;

    // Default mesh geometry.
    localparam int DEF_X_WIDTH = 2;
    localparam int DEF_Y_WIDTH = 2;

    // Fixed-width flit header fields above the destination address.
    localparam int SRC_W = 8;
    localparam int SEQ_W = 16;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_SATURATE = 2'b01,
        MODE_RATE     = 2'b10,
        MODE_SINGLE   = 2'b11
    } mode_e;

    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [31:0] ZERO_SEED   = 32'hACE1_0001;
    localparam logic [31:0] SEED_STRIDE = 32'h9E37_79B9;

    // Address field width for a mesh dimension; never narrower than one bit.
    function automatic int addr_bits(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // One step of the 32-bit right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/mesh_traffic_injector_lane.sv
// One injection lane: LFSR, credit counter, rate timer, sent counter and
// the registered flit builder. Lanes are fully independent of each other.
module mesh_traffic_injector_lane
    import mesh_traffic_injector_pkg::*;
#(
    parameter int LANE_ID      = 0,
    parameter int X_WIDTH      = DEF_X_WIDTH,
    parameter int Y_WIDTH      = DEF_Y_WIDTH,
    parameter int PACKET_WIDTH = 64,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_load,
    input  logic [31:0]             i_seed,
    input  logic                    i_run,
    input  mode_e                   i_mode,
    input  logic [15:0]             i_limit,
    input  logic [7:0]              i_period,
    input  logic                    i_credit,
    output logic [PACKET_WIDTH-1:0] o_flit,
    output logic                    o_valid,
    output logic [15:0]             o_sent,
    output logic                    o_finished,
    output logic                    o_full,
    output logic                    o_error
);

    localparam int X_ADDR = addr_bits(X_WIDTH);
    localparam int Y_ADDR = addr_bits(Y_WIDTH);
    localparam int PAY_W  = PACKET_WIDTH - X_ADDR - Y_ADDR - SRC_W - SEQ_W;
    localparam int CRED_W = $clog2(BUFFER_DEPTH + 1);
    localparam logic [CRED_W-1:0] FULL = CRED_W'(BUFFER_DEPTH);

    logic [31:0]             r_lfsr;
    logic [15:0]             r_sent;
    logic [7:0]              r_timer;
    logic [CRED_W-1:0]       r_credits;
    logic                    r_error;
    logic [PACKET_WIDTH-1:0] r_flit;
    logic                    r_valid;

    logic [31:0]       w_seed;
    logic [15:0]       w_eff_limit;
    logic [7:0]        w_reload;
    logic              w_at_limit;
    logic              w_gate;
    logic              w_issue;
    logic [X_ADDR-1:0] w_raw_x, w_dst_x;
    logic [Y_ADDR-1:0] w_raw_y, w_dst_y;
    logic [PAY_W-1:0]  w_payload;

    // Lane seed decorrelated by lane index; zero would lock the LFSR up.
    assign w_seed = ((i_seed ^ (32'(LANE_ID) * SEED_STRIDE)) == 32'h0)
                    ? ZERO_SEED : (i_seed ^ (32'(LANE_ID) * SEED_STRIDE));

    // Single-packet mode caps the campaign at one flit per lane.
    assign w_eff_limit = (i_mode == MODE_SINGLE && i_limit > 16'd1) ? 16'd1 : i_limit;
    assign w_at_limit  = (r_sent >= w_eff_limit);
    assign w_reload    = (i_period == 8'd0) ? 8'd0 : i_period - 8'd1;

    // Mode gate for the issue decision.
    // NOTE: the default assignment first keeps this purely combinational.
    always_comb begin
        w_gate = 1'b0;
        case (i_mode)
            MODE_SATURATE: w_gate = 1'b1;
            MODE_RATE:     w_gate = (r_timer == 8'd0);
            MODE_SINGLE:   w_gate = 1'b1;
            default:       w_gate = 1'b0;
        endcase
    end

    assign w_issue    = i_run && (r_credits != '0) && !w_at_limit && w_gate;
    assign o_finished = w_at_limit || (i_mode == MODE_OFF);
    assign o_full     = (r_credits == FULL);

    // Destinations fold out-of-range raw values back into the mesh.
    assign w_raw_x   = r_lfsr[X_ADDR-1:0];
    assign w_raw_y   = r_lfsr[X_ADDR +: Y_ADDR];
    assign w_dst_x   = (int'(w_raw_x) >= X_WIDTH) ? w_raw_x - X_ADDR'(X_WIDTH) : w_raw_x;
    assign w_dst_y   = (int'(w_raw_y) >= Y_WIDTH) ? w_raw_y - Y_ADDR'(Y_WIDTH) : w_raw_y;
    assign w_payload = PAY_W'(r_lfsr);

    // Lane state: credits, sent counter, LFSR, rate timer and output flit.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr    <= '0;
            r_sent    <= '0;
            r_timer   <= '0;
            r_credits <= FULL;
            r_error   <= 1'b0;
            r_flit    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_issue;
            if (i_credit && !w_issue) begin
                if (r_credits == FULL) r_error   <= 1'b1;
                else                   r_credits <= r_credits + 1'b1;
            end else if (w_issue && !i_credit) begin
                r_credits <= r_credits - 1'b1;
            end
            if (i_load) begin
                r_lfsr  <= w_seed;
                r_sent  <= '0;
                r_timer <= '0;
            end else if (w_issue) begin
                r_flit  <= {w_payload, r_sent, SRC_W'(LANE_ID), w_dst_y, w_dst_x};
                r_sent  <= r_sent + 16'd1;
                r_lfsr  <= lfsr_next(r_lfsr);
                r_timer <= w_reload;
            end else if (i_run && r_timer != 8'd0) begin
                r_timer <= r_timer - 8'd1;
            end
        end
    end

    assign o_flit  = r_flit;
    assign o_valid = r_valid;
    assign o_sent  = r_sent;
    assign o_error = r_error;

endmodule

// File: rtl/mesh_traffic_injector.sv
// Mesh edge traffic injector: campaign FSM, config latches and the
// done/error reduction over N_CHANNELS independent injection lanes.
module mesh_traffic_injector
    import mesh_traffic_injector_pkg::*;
#(
    parameter int N_CHANNELS   = 4,
    parameter int X_WIDTH      = DEF_X_WIDTH,
    parameter int Y_WIDTH      = DEF_Y_WIDTH,
    parameter int PACKET_WIDTH = 64,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_din,
    input  logic [1:0]                         mode_din,
    input  logic [15:0]                        packet_limit_din,
    input  logic [7:0]                         rate_period_din,
    input  logic [31:0]                        seed_din,
    output logic [N_CHANNELS*PACKET_WIDTH-1:0] channel_dout,
    output logic [N_CHANNELS-1:0]              channel_valid_dout,
    input  logic [N_CHANNELS-1:0]              credit_din,
    output logic [N_CHANNELS*16-1:0]           packets_sent_dout,
    output logic                               done_dout,
    output logic                               error_dout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  r_state;
    mode_e       r_mode;
    logic [15:0] r_limit;
    logic [7:0]  r_period;
    logic        r_done;

    logic                  w_start_ok;
    logic                  w_run;
    logic [N_CHANNELS-1:0] w_finished;
    logic [N_CHANNELS-1:0] w_full;
    logic [N_CHANNELS-1:0] w_error;

    // Start is only honoured between campaigns.
    assign w_start_ok = start_din && (r_state == S_IDLE || r_state == S_DONE);
    assign w_run      = (r_state == S_RUN);

    // Campaign sequencing and configuration capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mode   <= MODE_OFF;
            r_limit  <= '0;
            r_period <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_state  <= S_RUN;
                        r_mode   <= mode_e'(mode_din);
                        r_limit  <= packet_limit_din;
                        r_period <= rate_period_din;
                        r_done   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (&w_finished) r_state <= S_DRAIN;
                end
                default: begin
                    if (&w_full) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_lane
        mesh_traffic_injector_lane #(
            .LANE_ID      (g),
            .X_WIDTH      (X_WIDTH),
            .Y_WIDTH      (Y_WIDTH),
            .PACKET_WIDTH (PACKET_WIDTH),
            .BUFFER_DEPTH (BUFFER_DEPTH)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .i_load     (w_start_ok),
            .i_seed     (seed_din),
            .i_run      (w_run),
            .i_mode     (r_mode),
            .i_limit    (r_limit),
            .i_period   (r_period),
            .i_credit   (credit_din[g]),
            .o_flit     (channel_dout[g*PACKET_WIDTH +: PACKET_WIDTH]),
            .o_valid    (channel_valid_dout[g]),
            .o_sent     (packets_sent_dout[g*16 +: 16]),
            .o_finished (w_finished[g]),
            .o_full     (w_full[g]),
            .o_error    (w_error[g])
        );
    end

    assign done_dout  = r_done;
    assign error_dout = |w_error;

endmodule

// File: tb/tb_mesh_traffic_injector.sv
// Self-checking bench for mesh_traffic_injector: a campaign model pushes the
// expected flit stream per lane; a negedge monitor pops and compares.
module tb_mesh_traffic_injector;

    localparam int N  = 4;
    localparam int XW = 3;
    localparam int YW = 2;
    localparam int PW = 64;
    localparam int BD = 4;
    localparam int XA = 2;
    localparam int YA = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_din;
    logic [1:0]      mode_din;
    logic [15:0]     packet_limit_din;
    logic [7:0]      rate_period_din;
    logic [31:0]     seed_din;
    logic [N*PW-1:0] channel_dout;
    logic [N-1:0]    channel_valid_dout;
    logic [N-1:0]    credit_din;
    logic [N*16-1:0] packets_sent_dout;
    logic            done_dout;
    logic            error_dout;

    always #5 clk = ~clk;

    mesh_traffic_injector #(
        .N_CHANNELS(N), .X_WIDTH(XW), .Y_WIDTH(YW), .PACKET_WIDTH(PW), .BUFFER_DEPTH(BD)
    ) dut (
        .clk(clk), .reset(reset), .start_din(start_din), .mode_din(mode_din),
        .packet_limit_din(packet_limit_din), .rate_period_din(rate_period_din),
        .seed_din(seed_din), .channel_dout(channel_dout),
        .channel_valid_dout(channel_valid_dout), .credit_din(credit_din),
        .packets_sent_dout(packets_sent_dout), .done_dout(done_dout), .error_dout(error_dout)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [PW-1:0] exp_q  [N][$];
    int            pend_q [N][$];
    int            vcount [N];
    int            last_v [N];
    int            cred_policy = 0;   // 0 none, 1 fixed delay, 2 random delay
    int            cred_delay  = 1;
    int            rate_gap    = 0;   // expected valid spacing, 0 = unchecked

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model, straight from the flit and LFSR definitions.
    function automatic logic [31:0] galois(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [PW-1:0] model_flit(input int lane, input logic [31:0] l, input int seq);
        int rx, ry;
        rx = int'(l % (32'd1 << XA));
        if (rx >= XW) rx -= XW;
        ry = int'((l >> XA) % (32'd1 << YA));
        if (ry >= YW) ry -= YW;
        return PW'(rx) | (PW'(ry) << XA) | (PW'(lane) << (XA + YA))
             | (PW'(seq) << (XA + YA + 8)) | (PW'(l) << (XA + YA + 24));
    endfunction

    task automatic start_campaign(input logic [1:0] m, input int lim, input int per, input logic [31:0] seed);
        int n;
        logic [31:0] s;
        n = (m == 2'b00) ? 0 : (m == 2'b11) ? ((lim > 1) ? 1 : lim) : lim;
        for (int i = 0; i < N; i++) begin
            s = seed ^ (32'(i) * 32'h9E37_79B9);
            if (s == 32'h0) s = 32'hACE1_0001;
            exp_q[i].delete();
            for (int k = 0; k < n; k++) begin
                exp_q[i].push_back(model_flit(i, s, k));
                s = galois(s);
            end
            vcount[i] = 0;
            last_v[i] = -1;
        end
        rate_gap         = (m == 2'b10) ? ((per == 0) ? 1 : per) : 0;
        mode_din         = m;
        packet_limit_din = 16'(lim);
        rate_period_din  = 8'(per);
        seed_din         = seed;
        start_din        = 1'b1;
        @(posedge clk); #1;
        start_din        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            pend_q[i].delete();
            vcount[i] = 0;
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (!done_dout && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 64'(done_dout), 64'd1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic end_checks(input string tag, input int exp_sent);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_sent%0d", tag, i), 64'(packets_sent_dout[i*16 +: 16]), 64'(exp_sent));
            check($sformatf("%s_count%0d", tag, i), 64'(vcount[i]), 64'(exp_sent));
            check($sformatf("%s_leftover%0d", tag, i), 64'(exp_q[i].size()), 64'd0);
        end
    endtask

    // Monitor: compare every presented flit and schedule its credit return.
    always @(negedge clk) begin
        logic [PW-1:0] f;
        for (int i = 0; i < N; i++) begin
            if (channel_valid_dout[i]) begin
                f = channel_dout[i*PW +: PW];
                vcount[i]++;
                if (exp_q[i].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_flit lane%0d: got %0h expected none", i, f);
                end else begin
                    check($sformatf("flit_lane%0d", i), f, exp_q[i].pop_front());
                end
                check("dst_x_in_range", (int'(f[XA-1:0]) < XW) ? 64'd1 : 64'd0, 64'd1);
                if (rate_gap != 0 && last_v[i] >= 0)
                    check($sformatf("rate_gap_lane%0d", i), 64'(cyc - last_v[i]), 64'(rate_gap));
                last_v[i] = cyc;
                if (cred_policy == 1)      pend_q[i].push_back(cyc + cred_delay);
                else if (cred_policy == 2) pend_q[i].push_back(cyc + int'($urandom_range(1, 8)));
            end
        end
    end

    // Credit driver: at most one pulse per lane per cycle, earliest due first.
    initial begin
        credit_din = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                credit_din[i] = 1'b0;
                for (int k = 0; k < pend_q[i].size(); k++) begin
                    if (pend_q[i][k] <= cyc) begin
                        pend_q[i].delete(k);
                        credit_din[i] = 1'b1;
                        break;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] seed;
        int k;
        reset = 1'b1; start_din = 1'b0; mode_din = '0; packet_limit_din = '0;
        rate_period_din = '0; seed_din = '0;
        do_reset();
        check("rst_done", 64'(done_dout), 64'd0);
        check("rst_error", 64'(error_dout), 64'd0);
        check("rst_valid", 64'(channel_valid_dout), 64'd0);
        check("rst_flits", 64'(|channel_dout), 64'd0);
        check("rst_sent", 64'(|packets_sent_dout), 64'd0);

        // Saturate, limit 30, credits back 3 cycles after each flit.
        cred_policy = 1; cred_delay = 3;
        start_campaign(2'b01, 30, 0, $urandom);
        wait_done("sat_done", 400);
        end_checks("sat", 30);
        check("sat_error", 64'(error_dout), 64'd0);

        // Limit 0 finishes almost at once, with no flits.
        start_campaign(2'b01, 0, 0, $urandom);
        wait_done("lim0_done", 3);
        end_checks("lim0", 0);

        // Mode off and single-packet mode.
        start_campaign(2'b00, 7, 0, $urandom);
        wait_done("off_done", 10);
        end_checks("off", 0);
        start_campaign(2'b11, 5, 0, $urandom);
        wait_done("single_done", 20);
        end_checks("single", 1);

        // Fixed rate: period 5, then period 0 which behaves as 1.
        cred_delay = 1;
        start_campaign(2'b10, 6, 5, $urandom);
        wait_done("rate5_done", 100);
        end_checks("rate5", 6);
        start_campaign(2'b10, 3, 0, $urandom);
        wait_done("rate0_done", 30);
        end_checks("rate0", 3);

        // Reproducibility: same seed with fixed then random credit timing, zero seed too.
        seed = $urandom;
        start_campaign(2'b01, 20, 0, seed);
        wait_done("repro1_done", 400);
        end_checks("repro1", 20);
        cred_policy = 2;
        start_campaign(2'b01, 20, 0, seed);
        wait_done("repro2_done", 600);
        end_checks("repro2", 20);
        start_campaign(2'b01, 5, 0, 32'h0);
        wait_done("zseed_done", 200);
        end_checks("zseed", 5);

        // No credits returned: four flits then stall; four credits release four more.
        cred_policy = 0;
        start_campaign(2'b01, 8, 0, $urandom);
        wait_cycles(30);
        for (int i = 0; i < N; i++) check($sformatf("stall_count%0d", i), 64'(vcount[i]), 64'd4);
        check("stall_not_done", 64'(done_dout), 64'd0);
        for (int i = 0; i < N; i++) repeat (4) pend_q[i].push_back(cyc);
        wait_cycles(30);
        for (int i = 0; i < N; i++) check($sformatf("resume_count%0d", i), 64'(vcount[i]), 64'd8);
        check("resume_not_done", 64'(done_dout), 64'd0);
        for (int i = 0; i < N; i++) repeat (4) pend_q[i].push_back(cyc);
        wait_done("stall_done", 30);
        end_checks("stall", 8);

        // Excess credit: sticky error, counter stays saturated at the depth.
        pend_q[2].push_back(cyc);
        wait_cycles(5);
        check("err_set", 64'(error_dout), 64'd1);
        start_campaign(2'b01, 6, 0, $urandom);
        wait_cycles(30);
        check("err_sticky", 64'(error_dout), 64'd1);
        check("err_lane2_count", 64'(vcount[2]), 64'd4);
        check("err_lane2_sent", 64'(packets_sent_dout[2*16 +: 16]), 64'd4);

        // Reset mid-campaign, then a fresh short campaign.
        do_reset();
        check("rst2_error", 64'(error_dout), 64'd0);
        check("rst2_sent", 64'(|packets_sent_dout), 64'd0);
        cred_policy = 1; cred_delay = 3;
        start_campaign(2'b01, 30, 0, $urandom);
        k = 0;
        while (packets_sent_dout[15:0] < 16'd10 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("reach_ten", 64'(packets_sent_dout[15:0]), 64'd10);
        do_reset();
        check("midrst_sent", 64'(|packets_sent_dout), 64'd0);
        check("midrst_valid", 64'(channel_valid_dout), 64'd0);
        check("midrst_done", 64'(done_dout), 64'd0);
        start_campaign(2'b01, 5, 0, $urandom);
        wait_done("restart_done", 100);
        end_checks("restart", 5);
        check("restart_error", 64'(error_dout), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
